// File: rtl/flp_dec_pkg.sv
// -----------------------------------------------------------------------------
// flp_dec_pkg
// Shared types and constants for the float-to-decimal sequencer:
//   state_t     - sequencer states
//   FLP_BIAS    - IEEE-754 single-precision exponent bias
//   MANT_W      - significand width including the hidden bit
//   EXP_INF     - exponent field value of Inf/NaN
//   MAX_INT_EXP - largest unbiased exponent whose integer part fits MANT_W bits
//   NIBBLE_W    - width of one BCD digit
// Optional feature macro used by importers: FLP_DENORM_EN.
// -----------------------------------------------------------------------------
package flp_dec_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SPLIT,
      INT_CONV,
      FRAC_CONV,
      DONE
   } state_t;

   localparam int         FLP_BIAS    = 127;
   localparam int         MANT_W      = 24;
   localparam logic [7:0] EXP_INF     = 8'hFF;
   localparam int         MAX_INT_EXP = 23;
   localparam int         NIBBLE_W    = 4;

endpackage : flp_dec_pkg

// File: rtl/bcd_dd_step.sv
// -----------------------------------------------------------------------------
// bcd_dd_step
// One combinational double-dabble iteration: every BCD nibble >= 5 gets +3,
// then the whole accumulator shifts left by one with bit_in entering the LSB.
//
// Parameters:
//   DIGITS  - number of BCD digits in the accumulator
// Ports:
//   bcd_in  in   4*DIGITS  accumulator before this iteration
//   bit_in  in   1         next binary bit, MSB first
//   bcd_out out  4*DIGITS  accumulator after this iteration
// -----------------------------------------------------------------------------
module bcd_dd_step
   import flp_dec_pkg::*;
#(
   parameter int DIGITS = 8
) (
   input  logic [NIBBLE_W*DIGITS-1:0] bcd_in,
   input  logic                       bit_in,
   output logic [NIBBLE_W*DIGITS-1:0] bcd_out
);

   localparam int W = NIBBLE_W * DIGITS;

   logic [W-1:0] adj;

   // NOTE: every signal written in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      adj = bcd_in;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_in[i*NIBBLE_W +: NIBBLE_W] >= 4'd5) begin
            adj[i*NIBBLE_W +: NIBBLE_W] = bcd_in[i*NIBBLE_W +: NIBBLE_W] + 4'd3;
         end
      end
      bcd_out = {adj[W-2:0], bit_in};
   end

endmodule : bcd_dd_step

// File: rtl/flp_dec_seq.sv
// -----------------------------------------------------------------------------
// flp_dec_seq
// Multi-cycle converter from an IEEE-754 single to sign + packed-BCD integer
// digits + packed-BCD (truncated) fraction digits.
//   SPLIT     : significand split into integer field Q and 24-bit fraction F
//   INT_CONV  : 24 double-dabble iterations over Q, MSB first
//   FRAC_CONV : FRAC_DIGITS multiply-by-10 iterations over F
//   DONE      : results published, done pulses on the following cycle
//
// Build option: FLP_DENORM_EN
//   defined   - exp=0 is a denormal: e=-126, significand {0, frac}
//   undefined - exp=0 is flushed to zero (sign kept, err=0)
//
// Parameters:
//   INT_DIGITS  - BCD integer digits (>= 8 so that 2^24-1 fits)
//   FRAC_DIGITS - BCD fraction digits
// Ports:
//   clk      in   1              rising-edge clock
//   rst      in   1              synchronous active-high reset
//   start    in   1              conversion request, sampled in IDLE only
//   flp_in   in   32             operand, captured on accepted start
//   busy     out  1              conversion in progress
//   done     out  1              one-cycle result-valid pulse
//   sign     out  1              sign of the converted operand
//   int_bcd  out  4*INT_DIGITS   integer digits, MS digit in top nibble
//   frac_bcd out  4*FRAC_DIGITS  fraction digits, first digit in top nibble
//   err      out  1              Inf/NaN, or integer part wider than 24 bits
// -----------------------------------------------------------------------------
module flp_dec_seq
   import flp_dec_pkg::*;
#(
   parameter int INT_DIGITS  = 8,
   parameter int FRAC_DIGITS = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [31:0]                     flp_in,
   output logic                            busy,
   output logic                            done,
   output logic                            sign,
   output logic [NIBBLE_W*INT_DIGITS-1:0]  int_bcd,
   output logic [NIBBLE_W*FRAC_DIGITS-1:0] frac_bcd,
   output logic                            err
);

   localparam int IW    = NIBBLE_W * INT_DIGITS;
   localparam int FW    = NIBBLE_W * FRAC_DIGITS;
   localparam int CNT_W = $clog2(((MANT_W > FRAC_DIGITS) ? MANT_W : FRAC_DIGITS) + 1);

   localparam logic signed [8:0] BIAS_S   = 9'(FLP_BIAS);
   localparam logic signed [8:0] MAX_E    = 9'(MAX_INT_EXP);
   localparam logic signed [8:0] DENORM_E = 9'(1 - FLP_BIAS);

   state_t                state;
   logic [31:0]           flp_q;
   logic [MANT_W-1:0]     q_q;
   logic [MANT_W-1:0]     f_q;
   logic [IW-1:0]         int_acc;
   logic [FW-1:0]         frac_acc;
   logic                  err_q;
   logic [CNT_W-1:0]      cnt;

   // Split-stage combinational results, taken from the captured operand.
   logic [7:0]            exp_f;
   logic signed [8:0]     e_s;
   logic [MANT_W-1:0]     mant_split;
   logic [MANT_W-1:0]     q_split;
   logic [MANT_W-1:0]     f_split;
   logic                  err_split;
   logic [4:0]            int_sh;
   logic [8:0]            frac_sh;

   logic [IW-1:0]         int_next;
   logic [MANT_W+3:0]     prod;

   always_comb begin
      exp_f      = flp_q[30:23];
      e_s        = $signed({1'b0, exp_f}) - BIAS_S;
      mant_split = {1'b1, flp_q[22:0]};
      err_split  = 1'b0;
      q_split    = '0;
      f_split    = '0;
      int_sh     = '0;
      frac_sh    = '0;

      if (exp_f == 8'd0) begin
`ifdef FLP_DENORM_EN
         e_s        = DENORM_E;
         mant_split = {1'b0, flp_q[22:0]};
`else
         // Flushed: a zero significand drives both Q and F to zero below.
         mant_split = '0;
`endif
      end

      if (exp_f == EXP_INF || e_s > MAX_E) begin
         err_split = 1'b1;
      end else if (e_s >= 0) begin
         int_sh  = 5'(MAX_E - e_s);
         q_split = mant_split >> int_sh;
         // Bits below the binary point, left-aligned in 24 bits.
         f_split = mant_split << 5'(e_s + 9'sd1);
      end else begin
         // Whole value below 1: the hidden bit sits -e-1 places under the MSB of F.
         frac_sh = 9'(-e_s - 9'sd1);
         if (frac_sh < 9'(MANT_W)) begin
            f_split = mant_split >> frac_sh;
         end
      end
   end

   bcd_dd_step #(
      .DIGITS (INT_DIGITS)
   ) u_dd_step (
      .bcd_in  (int_acc),
      .bit_in  (q_q[MANT_W-1]),
      .bcd_out (int_next)
   );

   // F*10: the top nibble is the next decimal digit, the low 24 bits the remainder.
   assign prod = {4'b0, f_q} * 28'd10;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the datapath registers are reset along with the control state
         // so an aborted conversion leaves nothing behind to leak later.
         state    <= IDLE;
         flp_q    <= '0;
         q_q      <= '0;
         f_q      <= '0;
         int_acc  <= '0;
         frac_acc <= '0;
         err_q    <= 1'b0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sign     <= 1'b0;
         err      <= 1'b0;
         int_bcd  <= '0;
         frac_bcd <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  flp_q <= flp_in;
                  busy  <= 1'b1;
                  state <= SPLIT;
               end
            end

            SPLIT: begin
               q_q      <= q_split;
               f_q      <= f_split;
               err_q    <= err_split;
               int_acc  <= '0;
               frac_acc <= '0;
               cnt      <= '0;
               state    <= err_split ? DONE : INT_CONV;
            end

            INT_CONV: begin
               int_acc <= int_next;
               q_q     <= {q_q[MANT_W-2:0], 1'b0};
               if (cnt == CNT_W'(MANT_W - 1)) begin
                  cnt   <= '0;
                  state <= FRAC_CONV;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            FRAC_CONV: begin
               frac_acc <= (frac_acc << NIBBLE_W) | FW'(prod[MANT_W+3:MANT_W]);
               f_q      <= prod[MANT_W-1:0];
               if (cnt == CNT_W'(FRAC_DIGITS - 1)) begin
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            DONE: begin
               sign     <= flp_q[31];
               err      <= err_q;
               int_bcd  <= int_acc;
               frac_bcd <= frac_acc;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule : flp_dec_seq
